rx_tlp_sender: RTL and testbench

- Consumer side of the RX DMA trigger handshake: on each `trigger_tlp` / `change_huge_page` request it reads QWORDs from the internal RX buffer.
- Builds 64-bit-address PCIe Memory Write TLPs into the current host huge page and drives them onto the TRN transmit interface.
- Advances `commited_rd_address` and returns the acks.
- On page change it writes the page header QWORD and swaps to the next host-provided huge page.

---
 rtl/rx_tlp_sender_pkg.sv | 24 ++
 rtl/tlp_mwr64_hdr.sv | 25 ++
 rtl/rx_tlp_sender.sv | 185 ++++++++++++++++++
 tb/tb_rx_tlp_sender.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_tlp_sender_pkg.sv
// Shared constants and FSM encoding for the RX TLP sender.
// MWr64 fmt/type, page layout sizes, page-valid marker, states.
package rx_tlp_sender_pkg;

  localparam logic [1:0]  MWR64_FMT   = 2'b11;
  localparam logic [4:0]  MWR_TYPE    = 5'b00000;
  localparam int          RSVD_QW     = 16;
  localparam int          MAX_QW      = 16;
  localparam logic [31:0] PAGE_MARKER = 32'h0000_0001;

  typedef enum logic [3:0] {
    IDLE,
    GET_PAGE,
    HDR0,
    HDR1,
    DATA,
    DONE,
    PHDR0,
    PHDR1,
    PDATA,
    SWAP
  } state_t;

endpackage

// File: rtl/tlp_mwr64_hdr.sv
// Builds the two header QWs of a 4DW 64-bit Memory Write TLP.
// Ports: len (DW), req_id, addr in; hdr0 {DW0,DW1}, hdr1 {addr} out.
module tlp_mwr64_hdr
  import rx_tlp_sender_pkg::*;
(
  input  logic [9:0]  len,
  input  logic [15:0] req_id,
  input  logic [63:0] addr,
  output logic [63:0] hdr0,
  output logic [63:0] hdr1
);

  logic [31:0] dw0;
  logic [31:0] dw1;

  // TC, TD, EP, attr and tag are all zero.
  assign dw0 = {1'b0, MWR64_FMT, MWR_TYPE,
                1'b0, 3'b000, 4'b0000,
                1'b0, 1'b0, 2'b00, 2'b00, len};
  assign dw1 = {req_id, 8'h00, 4'hF, 4'hF};

  assign hdr0 = {dw0, dw1};
  assign hdr1 = {addr[63:32], addr[31:0]};

endmodule

// File: rtl/rx_tlp_sender.sv
// Reads QWs from the RX buffer and sends them as MWr64 TLPs into the
// current host huge page; closes pages with a header QW and swaps.
// Ports: clk/reset; trigger/change requests + acks; RX buffer rd port;
// huge page supply; TRN TX interface (active-low framing/handshake).
module rx_tlp_sender #(
  parameter int BUF_AW  = 10,
  parameter int RSVD_QW = rx_tlp_sender_pkg::RSVD_QW,
  parameter int MAX_QW  = rx_tlp_sender_pkg::MAX_QW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger_tlp,
  output logic              trigger_tlp_ack,
  input  logic              change_huge_page,
  input  logic              send_last_tlp_change_huge_page,
  output logic              change_huge_page_ack,
  input  logic [4:0]        qwords_to_send,
  output logic [BUF_AW-1:0] commited_rd_address,
  output logic [BUF_AW-1:0] rd_addr,
  input  logic [63:0]       rd_data,
  input  logic [63:0]       huge_page_base,
  input  logic              huge_page_valid,
  output logic              huge_page_consumed,
  input  logic [15:0]       cfg_completer_id,
  output logic [63:0]       trn_td,
  output logic              trn_tsof_n,
  output logic              trn_teof_n,
  output logic              trn_tsrc_rdy_n,
  input  logic              trn_tdst_rdy_n
);

  import rx_tlp_sender_pkg::*;

  localparam logic [18:0] RSVD = 19'(RSVD_QW);
  localparam logic [BUF_AW-1:0] ONE = BUF_AW'(1);

  state_t state, state_d;

  logic              trig_q, chg_q;
  logic              trig_pend, chg_pend;
  logic              trig_take, chg_take;
  logic              cur_chg, page_vld;
  logic [4:0]        n, cnt;
  logic [63:0]       base;
  logic [18:0]       offset;
  logic [BUF_AW-1:0] ptr;
  logic              accept, last_beat, pg_hdr;
  logic [9:0]        len;
  logic [63:0]       addr, hdr0, hdr1;

  assign accept    = ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n;
  assign last_beat = cnt == n - 5'd1;
  assign pg_hdr    = (state == PHDR0) | (state == PHDR1);
  assign len       = pg_hdr ? 10'd2 : {4'b0, n, 1'b0};
  assign addr      = base +
                     (pg_hdr ? 64'd0 : {42'b0, offset, 3'b000});

  tlp_mwr64_hdr u_hdr (
    .len    (len),
    .req_id (cfg_completer_id),
    .addr   (addr),
    .hdr0   (hdr0),
    .hdr1   (hdr1)
  );

  // ptr always names the QW rd_data holds; on an accepted beat the RAM
  // is already pointed at the next one so backpressure costs no bubble.
  assign rd_addr = (state == DATA && accept) ? ptr + ONE : ptr;

  assign trigger_tlp_ack      = (state == DONE) & ~cur_chg;
  assign change_huge_page_ack = state == SWAP;
  assign huge_page_consumed   = (state == GET_PAGE) & huge_page_valid;

  always_comb begin
    state_d   = state;
    trig_take = 1'b0;
    chg_take  = 1'b0;
    unique case (state)
      IDLE: begin
        if (chg_pend | trig_pend) begin
          if (!page_vld) begin
            state_d = GET_PAGE;
          end else if (chg_pend) begin
            chg_take = 1'b1;
            state_d  = send_last_tlp_change_huge_page ? HDR0 : PHDR0;
          end else begin
            trig_take = 1'b1;
            state_d   = HDR0;
          end
        end
      end
      GET_PAGE: if (huge_page_valid) state_d = IDLE;
      HDR0:     if (accept) state_d = HDR1;
      HDR1:     if (accept) state_d = DATA;
      DATA:     if (accept && last_beat) state_d = DONE;
      DONE:     state_d = cur_chg ? PHDR0 : IDLE;
      PHDR0:    if (accept) state_d = PHDR1;
      PHDR1:    if (accept) state_d = PDATA;
      PDATA:    if (accept) state_d = SWAP;
      SWAP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    trn_td         = 64'd0;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    unique case (state)
      HDR0, PHDR0: begin
        trn_tsrc_rdy_n = 1'b0;
        trn_tsof_n     = 1'b0;
        trn_td         = hdr0;
      end
      HDR1, PHDR1: begin
        trn_tsrc_rdy_n = 1'b0;
        trn_td         = hdr1;
      end
      DATA: begin
        trn_tsrc_rdy_n = 1'b0;
        trn_teof_n     = ~last_beat;
        trn_td         = rd_data;
      end
      PDATA: begin
        trn_tsrc_rdy_n = 1'b0;
        trn_teof_n     = 1'b0;
        trn_td         = {PAGE_MARKER, 13'd0, offset};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      trig_q              <= 1'b0;
      chg_q               <= 1'b0;
      trig_pend           <= 1'b0;
      chg_pend            <= 1'b0;
      cur_chg             <= 1'b0;
      page_vld            <= 1'b0;
      n                   <= 5'd0;
      cnt                 <= 5'd0;
      base                <= 64'd0;
      offset              <= RSVD;
      ptr                 <= '0;
      commited_rd_address <= '0;
    end else begin
      state  <= state_d;
      trig_q <= trigger_tlp;
      chg_q  <= change_huge_page;
      // Edges are remembered until served, so a trigger that
      // collides with a change is still sent afterwards.
      trig_pend <= (trig_pend & ~trig_take) |
                   (trigger_tlp & ~trig_q);
      chg_pend  <= (chg_pend & ~chg_take) |
                   (change_huge_page & ~chg_q);
      if (trig_take | chg_take) begin
        cur_chg <= chg_take;
        cnt     <= 5'd0;
        n       <= (qwords_to_send == 5'd0) ?
                   5'(MAX_QW) : qwords_to_send;
      end
      if (state == GET_PAGE && huge_page_valid) begin
        base     <= huge_page_base;
        page_vld <= 1'b1;
        offset   <= RSVD;
      end
      if (state == DATA && accept) begin
        ptr <= ptr + ONE;
        cnt <= cnt + 5'd1;
      end
      if (state == DONE) begin
        commited_rd_address <= commited_rd_address + BUF_AW'(n);
        offset              <= offset + 19'(n);
      end
      if (state == SWAP) begin
        page_vld <= 1'b0;
        offset   <= RSVD;
      end
    end
  end

endmodule

// File: tb/tb_rx_tlp_sender.sv
// Scoreboard bench for rx_tlp_sender.
// Expected TRN beats are queued at request time and popped per beat.
`timescale 1ns/1ps
module tb_rx_tlp_sender;

  localparam int AW = 10;
  localparam logic [15:0] CID = 16'hBEEF;
  localparam logic [63:0] B1 = 64'h0000_0001_0000_0000;
  localparam logic [63:0] B2 = 64'h0000_0002_0000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          trigger_tlp;
  logic          trigger_tlp_ack;
  logic          change_huge_page;
  logic          send_last;
  logic          change_huge_page_ack;
  logic [4:0]    qwords_to_send;
  logic [AW-1:0] commited_rd_address;
  logic [AW-1:0] rd_addr;
  logic [63:0]   rd_data;
  logic [63:0]   huge_page_base;
  logic          huge_page_valid;
  logic          huge_page_consumed;
  logic [63:0]   trn_td;
  logic          trn_tsof_n;
  logic          trn_teof_n;
  logic          trn_tsrc_rdy_n;
  logic          trn_tdst_rdy_n;

  always #2 clk = ~clk;

  rx_tlp_sender #(.BUF_AW(AW)) dut (
    .clk                            (clk),
    .reset                          (reset),
    .trigger_tlp                    (trigger_tlp),
    .trigger_tlp_ack                (trigger_tlp_ack),
    .change_huge_page               (change_huge_page),
    .send_last_tlp_change_huge_page (send_last),
    .change_huge_page_ack           (change_huge_page_ack),
    .qwords_to_send                 (qwords_to_send),
    .commited_rd_address            (commited_rd_address),
    .rd_addr                        (rd_addr),
    .rd_data                        (rd_data),
    .huge_page_base                 (huge_page_base),
    .huge_page_valid                (huge_page_valid),
    .huge_page_consumed             (huge_page_consumed),
    .cfg_completer_id               (CID),
    .trn_td                         (trn_td),
    .trn_tsof_n                     (trn_tsof_n),
    .trn_teof_n                     (trn_teof_n),
    .trn_tsrc_rdy_n                 (trn_tsrc_rdy_n),
    .trn_tdst_rdy_n                 (trn_tdst_rdy_n)
  );

  function automatic logic [63:0] qw(input logic [AW-1:0] a);
    return {16'hDA7A, 6'd0, a, ~{22'd0, a}};
  endfunction

  // RX buffer RAM with one cycle of read latency
  always @(posedge clk) rd_data <= qw(rd_addr);

  typedef struct packed {
    logic [63:0] td;
    logic        sof;
    logic        eof;
  } beat_t;

  beat_t sb[$];
  beat_t exp_b;
  int checks = 0;
  int failures = 0;
  int n_tack = 0;
  int n_cack = 0;
  int n_cons = 0;
  bit bp = 1'b0;
  bit got;
  bit busy;

  logic [63:0]   m_base;
  logic [18:0]   m_off;
  logic [AW-1:0] m_ptr = '0;
  bit            m_page = 1'b0;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (trigger_tlp_ack) n_tack++;
      if (change_huge_page_ack) n_cack++;
      if (huge_page_consumed) n_cons++;
      if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("FAIL beat_extra observed=%0h expected=none", trn_td);
        end
        if (sb.size() > 0) begin
          exp_b = sb.pop_front();
          checks++;
          assert ({trn_td, trn_tsof_n, trn_teof_n} ===
                  {exp_b.td, exp_b.sof, exp_b.eof}) else begin
            failures++;
            $error("FAIL beat observed=%0h/%b/%b expected=%0h/%b/%b",
                   trn_td, trn_tsof_n, trn_teof_n,
                   exp_b.td, exp_b.sof, exp_b.eof);
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hdr(input logic [9:0] len,
                          input logic [63:0] addr);
    sb.push_back('{td: {32'h6000_0000 | {22'd0, len}, CID, 16'h00FF},
                   sof: 1'b0, eof: 1'b1});
    sb.push_back('{td: addr, sof: 1'b1, eof: 1'b1});
  endtask

  task automatic model_data(input int n);
    logic [AW-1:0] a;
    if (!m_page) begin
      m_page = 1'b1;
      m_base = huge_page_base;
      m_off  = 19'd16;
    end
    push_hdr(10'(2 * n), m_base + (64'(m_off) << 3));
    for (int k = 0; k < n; k++) begin
      a = m_ptr + AW'(k);
      sb.push_back('{td: qw(a), sof: 1'b1, eof: (k != n - 1)});
    end
    m_ptr = m_ptr + AW'(n);
    m_off = m_off + 19'(n);
  endtask

  task automatic model_page();
    push_hdr(10'd2, m_base);
    sb.push_back('{td: {32'h1, 13'd0, m_off}, sof: 1'b1, eof: 1'b0});
    m_page = 1'b0;
  endtask

  task automatic wait_pulse(input bit chg, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (bp) trn_tdst_rdy_n = ~trn_tdst_rdy_n;
      @(negedge clk);
      seen = chg ? change_huge_page_ack : trigger_tlp_ack;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  task automatic trig(input int n, input logic [4:0] qts,
                      input int hold, input string tag);
    bit hb;
    hb = 1'b0;
    qwords_to_send = qts;
    model_data(n);
    trigger_tlp = 1'b1;
    wait_pulse(1'b0, tag);
    for (int k = 0; k < hold; k++) begin
      step();
      if (trn_tsrc_rdy_n !== 1'b1) hb = 1'b1;
    end
    if (hold > 0) chk("held_no_resend", 64'(hb), 64'd0);
    step();
    trigger_tlp    = 1'b0;
    trn_tdst_rdy_n = 1'b0;
    step();
  endtask

  initial begin
    reset            = 1'b1;
    trigger_tlp      = 1'b0;
    change_huge_page = 1'b0;
    send_last        = 1'b0;
    qwords_to_send   = 5'd16;
    huge_page_base   = 64'd0;
    huge_page_valid  = 1'b0;
    trn_tdst_rdy_n   = 1'b0;
    repeat (3) step();

    chk("rst_ctl", 64'({trigger_tlp_ack, change_huge_page_ack,
                        huge_page_consumed, trn_tsof_n,
                        trn_teof_n, trn_tsrc_rdy_n}), 64'b000111);
    chk("rst_td", trn_td, 64'd0);
    chk("rst_ptr", 64'({commited_rd_address, rd_addr}), 64'd0);
    reset = 1'b0;
    step();

    huge_page_base  = B1;
    huge_page_valid = 1'b1;
    trig(16, 5'd16, 0, "t1_ack");
    chk("t1_commit", 64'(commited_rd_address), 64'd16);
    chk("t1_consumed", 64'(n_cons), 64'd1);
    chk("t1_ack_count", 64'(n_tack), 64'd1);

    bp = 1'b1;
    trig(16, 5'd16, 0, "t2_bp_ack");
    bp = 1'b0;
    chk("t2_commit", 64'(commited_rd_address), 64'd32);

    trig(16, 5'd16, 10, "t3_ack");
    trig(16, 5'd16, 0, "t4_reraise_ack");
    chk("t4_commit", 64'(commited_rd_address), 64'd64);
    chk("t4_ack_count", 64'(n_tack), 64'd4);

    qwords_to_send = 5'd5;
    send_last      = 1'b1;
    model_data(5);
    model_page();
    huge_page_base = B2;
    model_data(5);
    trigger_tlp      = 1'b1;
    change_huge_page = 1'b1;
    wait_pulse(1'b1, "chg_ack");
    wait_pulse(1'b0, "trig_after_chg_ack");
    step();
    trigger_tlp      = 1'b0;
    change_huge_page = 1'b0;
    send_last        = 1'b0;
    step();
    chk("chg_commit", 64'(commited_rd_address), 64'd74);
    chk("chg_ack_count", 64'(n_cack), 64'd1);
    chk("chg_consumed", 64'(n_cons), 64'd2);

    for (int i = 0; i < 58; i++)
      trig(16, (i == 0) ? 5'd0 : 5'd16, 0, "loop_ack");
    trig(14, 5'd14, 0, "n14_ack");
    chk("pre_wrap_commit", 64'(commited_rd_address), 64'd1016);

    trig(16, 5'd16, 0, "wrap_ack");
    chk("wrap_commit", 64'(commited_rd_address), 64'd8);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("total_acks", 64'(n_tack), 64'd65);

    qwords_to_send = 5'd16;
    model_data(16);
    trigger_tlp = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      step();
      got = sb.size() <= 9;
    end
    chk("beat7_reached", 64'(got), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_ctl", 64'({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}),
        64'b111);
    chk("rst_mid_commit", 64'(commited_rd_address), 64'd0);
    sb.delete();
    m_page      = 1'b0;
    m_ptr       = '0;
    trigger_tlp = 1'b0;
    step();
    step();
    reset = 1'b0;
    busy  = 1'b0;
    repeat (30) begin
      step();
      if (trn_tsrc_rdy_n !== 1'b1) busy = 1'b1;
    end
    chk("rst_no_beats", 64'(busy), 64'd0);
    chk("rst_no_ack", 64'(n_tack), 64'd65);
    chk("rst_commit_hold", 64'(commited_rd_address), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
